// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host FSM state codes, command bytes, debug view and timing helper.
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND  = 8'hFE;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
  localparam logic [2:0] ST_ERR       = 3'd5;

  typedef struct packed {
    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic       clk_s;
    logic       data_s;
    logic       data_fall;
  } ps2_tx_dbg_t;

  function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned clk_hz);
    logic [63:0] prod;
    prod = 64'(us) * 64'(clk_hz);
    return 32'(prod / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 pad plus a falling-edge strobe on the synced level.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Lines idle high, so reset to 1 to avoid a spurious fall after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-edge frame, ACK check.
// Pads are open drain: an *_oe of 1 pulls the line low, 0 lets the pull-up win.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned START_TO_US = 15000,
  parameter int unsigned FRAME_TO_US = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_err,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output ps2_tx_dbg_t dbg_o
);

  localparam int unsigned INH_CYC   = us_to_cycles(INHIBIT_US, CLK_FREQ_HZ);
  localparam int unsigned START_CYC = us_to_cycles(START_TO_US, CLK_FREQ_HZ);
  localparam int unsigned FRAME_CYC = us_to_cycles(FRAME_TO_US, CLK_FREQ_HZ);
  localparam int unsigned MAX_A     = (INH_CYC > START_CYC) ? INH_CYC : START_CYC;
  localparam int unsigned MAX_CYC   = (MAX_A > FRAME_CYC) ? MAX_A : FRAME_CYC;
  localparam int          TW        = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] INH_LOAD   = TW'(INH_CYC - 1);
  localparam logic [TW-1:0] START_LOAD = TW'(START_CYC - 1);
  localparam logic [TW-1:0] FRAME_LOAD = TW'(FRAME_CYC - 1);

  logic clk_s, clk_fall, data_s, data_fall;

  ps2_line_sync u_clk_sync (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2_clk_i),
    .sync_o (clk_s),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2_data_i),
    .sync_o (data_s),
    .fall_o (data_fall)
  );

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cnt_q, cnt_d, cnt_nx;
  logic          oe_bit_q, oe_bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          par_q, par_d;

  // Handshake: a byte transfers on a cycle where tx_valid && tx_ready; tx_ready is high only in IDLE,
  // so a valid held through a frame is taken again only once the FSM is back in IDLE.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    oe_bit_d = oe_bit_q;
    byte_d   = byte_q;
    par_d    = par_q;
    cnt_nx   = cnt_q + 4'd1;
    if (timer_q != '0) timer_d = timer_q - TW'(1);

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        oe_bit_d = 1'b0;
        if (tx_valid) begin
          byte_d  = tx_data;
          par_d   = ~^tx_data;
          timer_d = INH_LOAD;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (timer_q == '0) begin
          timer_d = START_LOAD;
          state_d = ST_RTS;
        end
      end
      ST_RTS: begin
        if (clk_fall) begin
          timer_d  = FRAME_LOAD;
          cnt_d    = 4'd1;
          oe_bit_d = ~byte_q[0];
          state_d  = ST_SHIFT;
        end else if (timer_q == '0) begin
          state_d = ST_ERR;
        end
      end
      ST_SHIFT: begin
        if (clk_fall) begin
          cnt_d = cnt_nx;
          if (cnt_nx <= 4'd8) oe_bit_d = ~byte_q[3'(cnt_nx - 4'd1)];
          else if (cnt_nx == 4'd9) oe_bit_d = ~par_q;
          else oe_bit_d = 1'b0;
          if (cnt_nx == 4'd11) state_d = data_s ? ST_ERR : ST_WAIT_IDLE;
        end else if (timer_q == '0) begin
          state_d = ST_ERR;
        end
      end
      // The frame timer is deliberately not reloaded here: it bounds the whole frame.
      ST_WAIT_IDLE: begin
        if (clk_s && data_s) state_d = ST_IDLE;
        else if (timer_q == '0) state_d = ST_ERR;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      oe_bit_q <= 1'b0;
      byte_q   <= '0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      oe_bit_q <= oe_bit_d;
      byte_q   <= byte_d;
      par_q    <= par_d;
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign tx_busy     = (state_q != ST_IDLE);
  assign tx_done     = (state_q == ST_WAIT_IDLE) && clk_s && data_s;
  assign tx_err      = (state_q == ST_ERR);
  assign ps2_clk_oe  = (state_q == ST_INHIBIT);
  // Start bit goes low in the last inhibit cycle and is held through request-to-send.
  assign ps2_data_oe = ((state_q == ST_INHIBIT) && (timer_q == '0)) ||
                       (state_q == ST_RTS) ||
                       ((state_q == ST_SHIFT) && oe_bit_q);

  assign dbg_o.state     = state_q;
  assign dbg_o.bit_cnt   = cnt_q;
  assign dbg_o.clk_s     = clk_s;
  assign dbg_o.data_s    = data_s;
  assign dbg_o.data_fall = data_fall;

endmodule
